// File: rtl/tqv_bus_initiator.sv
// tqv_bus_initiator: queued command stream -> TinyQV peripheral register port.
// Commands are buffered in a FIFO and issued strictly in order; read results
// (and optionally write acks) come back on a valid/ready response channel.
// Optional feature macro: BUS_INIT_WRITE_ACK_EN (writes also produce a response).
module tqv_bus_initiator #(
   parameter int FIFO_DEPTH = 4,
   parameter int READ_WAIT  = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic [3:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_rdata,
   output logic [3:0] rsp_addr,
   output logic       rsp_write,
   output logic       busy,
   output logic [3:0] address,
   output logic       data_write,
   output logic [7:0] data_in,
   input  logic [7:0] data_out
);

   localparam int             AW      = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]    DEPTH_C = (AW+1)'(FIFO_DEPTH);
   localparam logic [2:0]     RW_LAST = 3'((READ_WAIT == 0) ? 0 : READ_WAIT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state, state_nx;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   logic            q_write [FIFO_DEPTH];
   logic [3:0]      q_addr  [FIFO_DEPTH];
   logic [7:0]      q_wdata [FIFO_DEPTH];
   logic            cur_write;
   logic [2:0]      wcnt;
   logic            full, empty, push, pop, capture;
`ifdef BUS_INIT_WRITE_ACK_EN
   logic            ack_wr;
`endif

   assign full      = (count == DEPTH_C);
   assign empty     = (count == '0);
   assign cmd_ready = !full;
   assign push      = cmd_valid && cmd_ready;
   assign busy      = !empty || (state != IDLE);

   // FIFO storage and occupancy; a full FIFO never pushes, even on a pop cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            q_write[wr_ptr] <= cmd_write;
            q_addr[wr_ptr]  <= cmd_addr;
            q_wdata[wr_ptr] <= cmd_wdata;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
   end

   // Next-state and per-cycle control decode
   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      capture  = 1'b0;
`ifdef BUS_INIT_WRITE_ACK_EN
      ack_wr   = 1'b0;
`endif
      case (state)
         IDLE: if (!empty) begin
            pop      = 1'b1;
            state_nx = ISSUE;
         end
         ISSUE: if (cur_write) begin
`ifdef BUS_INIT_WRITE_ACK_EN
            ack_wr   = 1'b1;
            state_nx = RESP;
`else
            state_nx = IDLE;
`endif
         end else if (READ_WAIT == 0) begin
            capture  = 1'b1;
            state_nx = RESP;
         end else begin
            state_nx = WAIT;
         end
         WAIT: if (wcnt == RW_LAST) begin
            capture  = 1'b1;
            state_nx = RESP;
         end
         RESP: if (rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State register and read-wait counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         wcnt  <= '0;
      end else begin
         state <= state_nx;
         if (state == ISSUE)     wcnt <= '0;
         else if (state == WAIT) wcnt <= wcnt + 3'd1;
      end
   end

   // Bus drive: load on pop, strobe is high only during ISSUE of a write
   always_ff @(posedge clk) begin
      if (rst) begin
         address    <= '0;
         data_in    <= '0;
         data_write <= 1'b0;
         cur_write  <= 1'b0;
      end else begin
         data_write <= pop && q_write[rd_ptr];
         if (pop) begin
            address   <= q_addr[rd_ptr];
            cur_write <= q_write[rd_ptr];
            if (q_write[rd_ptr]) data_in <= q_wdata[rd_ptr];
         end
      end
   end

   // Response register: loaded on capture/ack, held until handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_addr  <= '0;
      end else if (capture) begin
         rsp_valid <= 1'b1;
         rsp_rdata <= data_out;
         rsp_addr  <= address;
`ifdef BUS_INIT_WRITE_ACK_EN
      end else if (ack_wr) begin
         rsp_valid <= 1'b1;
         rsp_rdata <= data_in;
         rsp_addr  <= address;
`endif
      end else if (state == RESP && rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

`ifdef BUS_INIT_WRITE_ACK_EN
   // Distinguishes write acks from read data in the held response
   always_ff @(posedge clk) begin
      if (rst)          rsp_write <= 1'b0;
      else if (capture) rsp_write <= 1'b0;
      else if (ack_wr)  rsp_write <= 1'b1;
   end
`else
   assign rsp_write = 1'b0;
`endif

endmodule

// File: tb/tb_tqv_bus_initiator.sv
// Directed bench for tqv_bus_initiator: a READ_WAIT=0 instance on a register
// model peripheral, plus a READ_WAIT=2 instance with bench-driven data_out.
module tb_tqv_bus_initiator;

`ifdef BUS_INIT_WRITE_ACK_EN
   localparam bit ACK = 1'b1;
   localparam int GAP = 3;
   localparam int DROP = 2;
`else
   localparam bit ACK = 1'b0;
   localparam int GAP = 2;
   localparam int DROP = 1;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid, cmd_ready, cmd_write;
   logic [3:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       rsp_valid, rsp_ready, rsp_write, busy, data_write;
   logic [7:0] rsp_rdata, data_in, data_out;
   logic [3:0] rsp_addr, address;

   logic       b_cmd_valid, b_cmd_ready, b_cmd_write;
   logic [3:0] b_cmd_addr;
   logic [7:0] b_cmd_wdata;
   logic       b_rsp_valid, b_rsp_ready, b_rsp_write, b_busy, b_data_write;
   logic [7:0] b_rsp_rdata, b_data_in, b_data_out;
   logic [3:0] b_rsp_addr, b_address;

   logic [7:0] regs [16];
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   tqv_bus_initiator #(.FIFO_DEPTH(4), .READ_WAIT(0)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_addr(rsp_addr), .rsp_write(rsp_write), .busy(busy),
      .address(address), .data_write(data_write), .data_in(data_in),
      .data_out(data_out));

   tqv_bus_initiator #(.FIFO_DEPTH(4), .READ_WAIT(2)) dut2 (
      .clk(clk), .rst(rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
      .cmd_write(b_cmd_write), .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
      .rsp_addr(b_rsp_addr), .rsp_write(b_rsp_write), .busy(b_busy),
      .address(b_address), .data_write(b_data_write), .data_in(b_data_in),
      .data_out(b_data_out));

   // register-model peripheral
   always @(posedge clk) if (data_write) regs[address] <= data_in;
   assign data_out = regs[address];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic nx();
      @(posedge clk); #1;
   endtask

   task automatic wr_test(input logic [3:0] a, input logic [7:0] d);
      rsp_ready = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_wdata = d;
      nx();
      cmd_valid = 1'b0;
      chk("wr_pre_strobe", data_write, 1'b0);
      nx();
      chk("wr_strobe", data_write, 1'b1);
      chk("wr_addr", address, a);
      chk("wr_data", data_in, d);
      nx();
      chk("wr_strobe_1cyc", data_write, 1'b0);
      if (ACK) begin
         chk("wr_ack_valid", rsp_valid, 1'b1);
         chk("wr_ack_write", rsp_write, 1'b1);
         chk("wr_ack_addr", rsp_addr, a);
         chk("wr_ack_data", rsp_rdata, d);
      end else begin
         chk("wr_no_rsp", rsp_valid, 1'b0);
         chk("wr_rsp_write0", rsp_write, 1'b0);
      end
      nx(); nx();
      chk("wr_rsp_clear", rsp_valid, 1'b0);
      chk("wr_idle", busy, 1'b0);
   endtask

   initial begin
      int k, last;
      for (int i = 0; i < 16; i++) regs[i] = 8'h00;
      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b1;
      b_cmd_valid = 1'b0; b_cmd_write = 1'b0; b_cmd_addr = '0; b_cmd_wdata = '0;
      b_rsp_ready = 1'b1; b_data_out = 8'h11;
      nx(); nx();
      // reset state
      chk("rst_address", address, 4'h0);
      chk("rst_data_write", data_write, 1'b0);
      chk("rst_data_in", data_in, 8'h00);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_rdata", rsp_rdata, 8'h00);
      chk("rst_rsp_addr", rsp_addr, 4'h0);
      chk("rst_rsp_write", rsp_write, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      rst = 1'b0;
      nx();

      // 1: single write
      wr_test(4'h0, 8'h12);

      // 2: read back, response held while rsp_ready=0
      rsp_ready = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h0;
      nx();
      cmd_valid = 1'b0;
      nx();
      chk("rd_issue_addr", address, 4'h0);
      chk("rd_issue_norsp", rsp_valid, 1'b0);
      nx();
      for (int i = 0; i < 4; i++) begin
         chk("rd_valid_hold", rsp_valid, 1'b1);
         chk("rd_data_hold", rsp_rdata, 8'h12);
         chk("rd_addr_hold", rsp_addr, 4'h0);
         chk("rd_write_flag", rsp_write, 1'b0);
         if (i < 3) nx();
      end
      rsp_ready = 1'b1;
      nx();
      chk("rd_handshake", rsp_valid, 1'b0);
      nx();

      // 3: backpressure fills FIFO, then writes drain in order
      rsp_ready = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h1;
      nx();
      for (int i = 0; i < 4; i++) begin
         cmd_write = 1'b1; cmd_addr = 4'(4 + i); cmd_wdata = 8'(8'h41 + i);
         nx();
      end
      chk("full_ready", cmd_ready, 1'b0);
      chk("full_busy", busy, 1'b1);
      cmd_addr = 4'hF; cmd_wdata = 8'hEE;
      nx();
      chk("full_no_take", cmd_ready, 1'b0);
      cmd_valid = 1'b0;
      chk("bp_rsp_valid", rsp_valid, 1'b1);
      chk("bp_rsp_data", rsp_rdata, 8'h00);
      chk("bp_rsp_addr", rsp_addr, 4'h1);
      rsp_ready = 1'b1;
      k = 0; last = -1;
      for (int c = 0; c < 40; c++) begin
         nx();
         if (data_write) begin
            if (k < 4) begin
               chk("drain_addr", address, 4'(4 + k));
               chk("drain_data", data_in, 8'(8'h41 + k));
            end
            if (k > 0) chk("drain_gap", c - last, GAP);
            last = c; k++;
         end
         if (k == 4 && c == last + DROP) chk("drain_busy_drop", busy, 1'b0);
         if (k == 4 && c == last + DROP - 1) chk("drain_busy_hold", busy, 1'b1);
      end
      chk("drain_count", k, 4);

      // 4: READ_WAIT=2 instance, data changes on the third address cycle
      b_cmd_valid = 1'b1; b_cmd_write = 1'b0; b_cmd_addr = 4'h7;
      nx();
      b_cmd_valid = 1'b0;
      nx();
      chk("rw_addr_c1", b_address, 4'h7);
      chk("rw_norsp_c1", b_rsp_valid, 1'b0);
      nx();
      chk("rw_addr_c2", b_address, 4'h7);
      chk("rw_norsp_c2", b_rsp_valid, 1'b0);
      nx();
      b_data_out = 8'h5A;
      chk("rw_addr_c3", b_address, 4'h7);
      chk("rw_norsp_c3", b_rsp_valid, 1'b0);
      nx();
      chk("rw_rsp_valid", b_rsp_valid, 1'b1);
      chk("rw_rsp_data", b_rsp_rdata, 8'h5A);
      chk("rw_rsp_addr", b_rsp_addr, 4'h7);
      nx();
      chk("rw_handshake", b_rsp_valid, 1'b0);

      // 5: reset during a write strobe with commands still queued
      rsp_ready = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h0;
      nx();
      for (int i = 0; i < 3; i++) begin
         cmd_write = 1'b1; cmd_addr = 4'(8 + i); cmd_wdata = 8'(8'h81 + i);
         nx();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      nx();
      nx();
      chk("rs_strobe_pre", data_write, 1'b1);
      chk("rs_strobe_addr", address, 4'h8);
      rst = 1'b1;
      nx();
      chk("rs_strobe_cut", data_write, 1'b0);
      chk("rs_cmd_ready", cmd_ready, 1'b1);
      chk("rs_busy", busy, 1'b0);
      chk("rs_rsp_valid", rsp_valid, 1'b0);
      rst = 1'b0;
      k = 0;
      for (int c = 0; c < 12; c++) begin
         nx();
         if (data_write) k++;
      end
      chk("rs_no_issue", k, 0);

      // 6: write ack (or lack of one)
      wr_test(4'h3, 8'hA5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
